// File: rtl/led_step_scheduler.sv
// LED step scheduler: arbitrates manual up/down pulses against a timed auto-stepper
// Latency: one clock from a sampled request or a prescaler wrap to the registered cnt/step outputs
// Backpressure: none; requests are single-cycle pulses acted on (or dropped) in the cycle they arrive
module led_step_scheduler #(
  parameter int WIDTH   = 3,
  parameter int CNT_MAX = 7,
  parameter int DIV     = 12000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_req,
  input  logic             down_req,
  input  logic             mode_req,
  output logic [WIDTH-1:0] cnt,
  output logic             auto_on,
  output logic             dir,
  output logic             step
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] CMAX     = WIDTH'(CNT_MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_UP   = 2'd1,
    ST_AUTO_DOWN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [PW-1:0]    r_pre;
  logic             r_auto_on;
  logic             r_dir;
  logic             r_step;

  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_dec;
  logic             w_up_only;
  logic             w_down_only;
  logic             w_pre_wrap;

  // Wrapping neighbours of the current count and cleaned-up request decode
  always_comb begin
    w_cnt_inc   = (r_cnt == CMAX) ? '0 : r_cnt + 1'b1;
    w_cnt_dec   = (r_cnt == '0) ? CMAX : r_cnt - 1'b1;
    w_up_only   = up_req & ~down_req;
    w_down_only = down_req & ~up_req;
    w_pre_wrap  = (r_pre == PRE_LAST);
  end

  // Mode FSM, prescaler and count; step marks every edge on which cnt changes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_MANUAL;
      r_cnt     <= '0;
      r_pre     <= '0;
      r_auto_on <= 1'b0;
      r_dir     <= 1'b1;
      r_step    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_AUTO_UP, ST_AUTO_DOWN: begin
          if (mode_req) begin
            // leaving auto: count freezes, dir keeps the last auto direction
            r_state   <= ST_MANUAL;
            r_auto_on <= 1'b0;
            r_pre     <= '0;
          end else if (r_state == ST_AUTO_DOWN && w_up_only) begin
            r_state <= ST_AUTO_UP;
            r_dir   <= 1'b1;
            r_pre   <= '0;
          end else if (r_state == ST_AUTO_UP && w_down_only) begin
            r_state <= ST_AUTO_DOWN;
            r_dir   <= 1'b0;
            r_pre   <= '0;
          end else if (w_pre_wrap) begin
            r_pre  <= '0;
            r_cnt  <= (r_state == ST_AUTO_UP) ? w_cnt_inc : w_cnt_dec;
            r_step <= 1'b1;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        default: begin
          // manual: prescaler parked at zero so auto entry always starts a full period
          r_pre <= '0;
          if (mode_req) begin
            r_state   <= r_dir ? ST_AUTO_UP : ST_AUTO_DOWN;
            r_auto_on <= 1'b1;
          end else if (w_up_only) begin
            r_cnt  <= w_cnt_inc;
            r_dir  <= 1'b1;
            r_step <= 1'b1;
          end else if (w_down_only) begin
            r_cnt  <= w_cnt_dec;
            r_dir  <= 1'b0;
            r_step <= 1'b1;
          end
        end
      endcase
    end
  end

  assign cnt     = r_cnt;
  assign auto_on = r_auto_on;
  assign dir     = r_dir;
  assign step    = r_step;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Bench for led_step_scheduler: directed pulses, expected step results queued per DUT
// and popped by a monitor whenever step is observed; direct checks cover holds and timing.
module tb_led_step_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_req = 1'b0, down_req = 1'b0, mode_req = 1'b0;
  logic       up5 = 1'b0, down5 = 1'b0, mode5 = 1'b0;
  logic [2:0] cnt, cnt5;
  logic       auto_on, dir, step;
  logic       auto_on5, dir5, step5;

  int n_checks = 0;
  int n_errors = 0;

  // expected {cnt, dir, auto_on} for each step pulse
  logic [4:0] q7[$];
  logic [4:0] q5[$];

  always #5 clk = ~clk;

  led_step_scheduler #(.WIDTH(3), .CNT_MAX(7), .DIV(4)) dut (
    .clk(clk), .reset(reset), .up_req(up_req), .down_req(down_req), .mode_req(mode_req),
    .cnt(cnt), .auto_on(auto_on), .dir(dir), .step(step)
  );

  led_step_scheduler #(.WIDTH(3), .CNT_MAX(5), .DIV(4)) dut5 (
    .clk(clk), .reset(reset), .up_req(up5), .down_req(down5), .mode_req(mode5),
    .cnt(cnt5), .auto_on(auto_on5), .dir(dir5), .step(step5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitors: every observed step must match the next queued expectation
  always @(negedge clk) begin
    if (step) begin
      if (q7.size() == 0) chk("unexpected_step7", {29'd0, cnt}, 32'd99);
      else chk("step7_cnt_dir_auto", {27'd0, cnt, dir, auto_on}, {27'd0, q7.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (step5) begin
      if (q5.size() == 0) chk("unexpected_step5", {29'd0, cnt5}, 32'd99);
      else chk("step5_cnt_dir_auto", {27'd0, cnt5, dir5, auto_on5}, {27'd0, q5.pop_front()});
    end
  end

  task automatic pulse(input logic u, input logic d, input logic m);
    up_req = u; down_req = d; mode_req = m;
    tick(1);
    up_req = 1'b0; down_req = 1'b0; mode_req = 1'b0;
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_cnt", cnt, 0);
    chk("rst_auto", auto_on, 0);
    chk("rst_dir", dir, 1);
    chk("rst_step", step, 0);
    reset = 1'b0;
    tick(1);

    // 1: eight up pulses, wrapping 7 -> 0
    for (int i = 1; i <= 8; i++) begin
      q7.push_back({3'(i % 8), 1'b1, 1'b0});
      pulse(1, 0, 0);
      tick(2);
    end
    chk("t1_cnt", cnt, 0);
    chk("t1_dir", dir, 1);

    // 2: down from 0 wraps to 7; simultaneous up+down cancels
    q7.push_back({3'd7, 1'b0, 1'b0});
    pulse(0, 1, 0);
    tick(2);
    pulse(1, 1, 0);
    chk("t2_cancel_step", step, 0);
    tick(2);
    chk("t2_cnt", cnt, 7);
    chk("t2_dir", dir, 0);

    // 3: get to cnt=2 dir=1, enter auto-up, steps at E4, E8, E12
    for (int v = 0; v <= 2; v++) begin
      q7.push_back({3'(v), 1'b1, 1'b0});
      pulse(1, 0, 0);
      tick(1);
    end
    q7.push_back({3'd3, 1'b1, 1'b1});
    q7.push_back({3'd4, 1'b1, 1'b1});
    q7.push_back({3'd5, 1'b1, 1'b1});
    pulse(0, 0, 1);                      // after E0
    chk("t3_auto_on", auto_on, 1);
    chk("t3_dir", dir, 1);
    tick(3);                             // after E3
    chk("t3_e3_cnt", cnt, 2);
    chk("t3_e3_step", step, 0);
    tick(1);                             // after E4
    chk("t3_e4_cnt", cnt, 3);
    chk("t3_e4_step", step, 1);
    tick(1);
    chk("t3_e5_step", step, 0);
    tick(7);                             // after E12
    chk("t3_e12_cnt", cnt, 5);
    chk("t3_e12_step", step, 1);

    // 4: prescaler=2 after two more edges; down_req reverses with no step
    tick(2);
    pulse(0, 1, 0);
    chk("t4_dir", dir, 0);
    chk("t4_step", step, 0);
    chk("t4_cnt", cnt, 5);
    chk("t4_auto", auto_on, 1);
    q7.push_back({3'd4, 1'b0, 1'b1});
    q7.push_back({3'd3, 1'b0, 1'b1});
    tick(3);
    chk("t4_hold_cnt", cnt, 5);
    tick(1);
    chk("t4_first_cnt", cnt, 4);
    chk("t4_first_step", step, 1);
    tick(4);
    chk("t4_second_cnt", cnt, 3);

    // 5: back to auto-up, then mode+up together exits to manual, count frozen
    pulse(1, 0, 0);
    chk("t5_rev_dir", dir, 1);
    chk("t5_rev_step", step, 0);
    chk("t5_rev_cnt", cnt, 3);
    tick(1);
    pulse(1, 0, 1);
    chk("t5_auto_off", auto_on, 0);
    chk("t5_cnt", cnt, 3);
    chk("t5_step", step, 0);
    tick(10);
    chk("t5_idle_cnt", cnt, 3);
    chk("t5_idle_auto", auto_on, 0);

    // 6: down to 0, auto-down, reset at prescaler=3
    for (int v = 2; v >= 0; v--) begin
      q7.push_back({3'(v), 1'b0, 1'b0});
      pulse(0, 1, 0);
      tick(1);
    end
    pulse(0, 0, 1);
    chk("t6_auto_on", auto_on, 1);
    chk("t6_dir", dir, 0);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_auto", auto_on, 0);
    chk("t6_rst_dir", dir, 1);
    chk("t6_rst_step", step, 0);
    tick(10);
    chk("t6_idle_cnt", cnt, 0);
    chk("t6_idle_auto", auto_on, 0);

    // CNT_MAX=5 variant: manual up to 4, then auto-up gives 5, 0, 1
    for (int v = 1; v <= 4; v++) begin
      q5.push_back({3'(v), 1'b1, 1'b0});
      up5 = 1'b1; tick(1); up5 = 1'b0; tick(1);
    end
    q5.push_back({3'd5, 1'b1, 1'b1});
    q5.push_back({3'd0, 1'b1, 1'b1});
    q5.push_back({3'd1, 1'b1, 1'b1});
    mode5 = 1'b1; tick(1); mode5 = 1'b0;
    tick(12);
    chk("c5_final_cnt", cnt5, 1);
    tick(2);

    chk("q7_drained", q7.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_step_scheduler.md
Name: led_step_scheduler

Overview:
Controller that sequences the LED step counter. It arbitrates between debounced up/down button pulses and an internal auto-run stepper, and owns the count value driven into the LED decoder. A mode pulse toggles between manual stepping and timed auto-stepping. Button pulses arrive already debounced, one clock wide.

Parameters:
WIDTH, 3, count width; the cnt output width.
CNT_MAX, 7, highest count value; the count wraps at this value. Must be at most 2^WIDTH-1 and at least 1.
DIV, 12000000, clocks per auto step. Must be at least 2. The bench overrides it to 4.

Ports:
clk  input  1  single clock, all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
up_req  input  1  one-cycle pulse from the up-button debouncer.
down_req  input  1  one-cycle pulse from the down-button debouncer.
mode_req  input  1  one-cycle pulse; toggles manual/auto mode.
cnt  output  WIDTH  current count, fed to the LED decoder.
auto_on  output  1  1 while in an AUTO state.
dir  output  1  current direction: 1 = up, 0 = down.
step  output  1  1 for exactly the cycle in which cnt shows a newly changed value.

Behaviour:
- One clock, one synchronous active-high reset. The clock is clk and the reset is reset. Reset is sampled on the rising edge of clk.
- Reset values: cnt=0, state=MANUAL, auto_on=0, dir=1, step=0, prescaler=0.
- Reset mid-operation, in any state: the next edge with reset=1 restores all reset values. No step pulse is produced on that edge.
- All outputs are registered.
- Arithmetic:
  - Increment: CNT_MAX goes to 0; otherwise cnt+1.
  - Decrement: 0 goes to CNT_MAX; otherwise cnt-1.
  - cnt never exceeds CNT_MAX.
- Priority on any edge: reset > mode_req > up_req/down_req > prescaler step.
- FSM states: MANUAL, AUTO_UP, AUTO_DOWN.
- dir and auto_on are decoded from the state. In MANUAL, dir holds its last value.
- MANUAL state:
  - up_req alone: increment and set dir=1.
  - down_req alone: decrement and set dir=0.
  - up_req and down_req in the same cycle: cancel. cnt and dir hold, step=0.
  - mode_req: go to AUTO_UP if dir=1, else AUTO_DOWN. Clear the prescaler. Any up/down pulse in the same cycle is ignored.
  - The prescaler is held at 0 in MANUAL.
- AUTO states:
  - The prescaler increments every edge.
  - On the edge where prescaler==DIV-1: step cnt in the state direction and return the prescaler to 0.
  - The first auto step lands DIV edges after the edge that sampled mode_req. After that, one step every DIV edges.
  - up_req while in AUTO_DOWN: go to AUTO_UP, set dir=1, clear the prescaler, no step on that edge.
  - down_req while in AUTO_UP: go to AUTO_DOWN, set dir=0, clear the prescaler, no step on that edge.
  - A request in the already-active direction is ignored; the prescaler continues.
  - up_req and down_req together: ignored; the prescaler continues.
  - mode_req: go to MANUAL, clear the prescaler, cnt holds, no step.
- step:
  - Asserted on the edge where cnt changes, so it is high in the same cycle the new cnt is visible.
  - Never asserted when cnt holds.
  - Never high for two consecutive cycles unless cnt changes on two consecutive edges (manual pulses on back-to-back cycles).
- Wrap example: with CNT_MAX=5 and auto-up, the sequence is 4,5,0,1.

Test Plan:
1. Reset, then 8 up_req pulses spaced 3 cycles apart -> cnt goes 1,2,...,7,0. step=1 on each change. dir=1.
2. From cnt=0, one down_req pulse -> cnt=7, dir=0, step pulse. Then up_req and down_req in the same cycle -> cnt stays 7, step=0.
3. DIV=4, cnt=2, dir=1, mode_req at edge E0 -> auto_on=1 after E0. cnt=3 at E4, 4 at E8, 5 at E12. step high only in the cycles after E4, E8 and E12.
4. In AUTO_UP with cnt=5 and prescaler=2, down_req -> AUTO_DOWN, dir=0, no step that edge. cnt=4 exactly 4 edges later, then 3 after 4 more.
5. In AUTO_UP, mode_req together with up_req -> MANUAL, auto_on=0, cnt unchanged, no step for 10 idle cycles.
6. In AUTO_DOWN with cnt=0 and prescaler=3, reset=1 for one edge -> cnt=0, auto_on=0, dir=1, step=0, and no change for 10 idle cycles. CNT_MAX=5 variant: auto-up from 4 -> 5, 0, 1.
